// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 5-stage core.
package mips32_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic             halt;
    } sb_entry_t;

endpackage

// File: rtl/mips32_scoreboard.sv
// Three-deep shift register of in-flight destinations (EX, MEM, WB) with
// parallel source-register match for the ID stage.
module mips32_scoreboard
    import mips32_pkg::*;
#(
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  sb_entry_t        entry_in,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             rs_match,
    output logic             rt_match,
    output logic             wb_halt
);

    // With WB bypass the register file already holds the WB result when ID reads.
    localparam int unsigned NCHK = (WB_BYPASS != 0) ? 2 : 3;

    sb_entry_t sb [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= entry_in;
            sb[1] <= sb[0];
            sb[2] <= sb[1];
        end
    end

    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        for (int unsigned i = 0; i < NCHK; i++) begin
            if (sb[i].valid && sb[i].wr && (sb[i].rd == rs)) rs_match = 1'b1;
            if (sb[i].valid && sb[i].wr && (sb[i].rd == rt)) rt_match = 1'b1;
        end
        if (rs == REG_ZERO) rs_match = 1'b0;
        if (rt == REG_ZERO) rt_match = 1'b0;
    end

    assign wb_halt = sb[2].halt;

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// Pipeline interlock controller: RAW stalls in ID, wrong-path flush on taken
// branches, HLT sequencing to a sticky halted state, and a stall counter.
module mips32_hazard_ctrl
    import mips32_pkg::*;
#(
    parameter int unsigned WB_BYPASS = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_halt,
    input  logic             ex_branch_taken,
    output logic             pc_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             fetch_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    logic      halt_pending;
    logic      rs_match;
    logic      rt_match;
    logic      wb_halt;
    logic      hazard;
    logic      flush;
    logic      stall;
    logic      issue;
    sb_entry_t entry_in;

    mips32_scoreboard #(
        .WB_BYPASS(WB_BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .entry_in (entry_in),
        .rs       (id_rs),
        .rt       (id_rt),
        .rs_match (rs_match),
        .rt_match (rt_match),
        .wb_halt  (wb_halt)
    );

    always_comb begin
        flush    = ex_branch_taken;
        hazard   = id_valid && !halt_pending &&
                   ((id_use_rs && rs_match) || (id_use_rt && rt_match));
        stall    = hazard && !flush;
        issue    = id_valid && !halt_pending && !stall && !flush;
        entry_in = '0;
        if (issue) begin
            entry_in.valid = 1'b1;
            entry_in.wr    = id_wr_en;
            entry_in.rd    = id_rd;
            entry_in.halt  = id_is_halt;
        end
    end

    // Reset forces a quiet front end: nothing fetched, NOPs in both latches.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        fetch_en    = 1'b0;
        if (!rst) begin
            pc_hold     = stall;
            ifid_flush  = flush;
            idex_bubble = stall || flush || halt_pending;
            fetch_en    = !halt_pending && !halted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_pending <= 1'b0;
            halted       <= 1'b0;
            stall_count  <= '0;
        end else begin
            if (issue && id_is_halt) halt_pending <= 1'b1;
            if (wb_halt)             halted       <= 1'b1;
            if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// Directed bench for mips32_hazard_ctrl: a per-cycle vector table plus
// hand-written sequences for WB_BYPASS=0, HLT and reset mid-stall.
module tb_mips32_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  id_rd;
    logic        id_wr_en;
    logic        id_is_halt;
    logic        ex_branch_taken;

    logic        pc_hold, ifid_flush, idex_bubble, fetch_en, halted;
    logic [15:0] stall_count;
    logic        pc_hold0, ifid_flush0, idex_bubble0, fetch_en0, halted0;
    logic [15:0] stall_count0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips32_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_halt(id_is_halt), .ex_branch_taken(ex_branch_taken),
        .pc_hold(pc_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fetch_en(fetch_en), .halted(halted), .stall_count(stall_count)
    );

    mips32_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_halt(id_is_halt), .ex_branch_taken(ex_branch_taken),
        .pc_hold(pc_hold0), .ifid_flush(ifid_flush0), .idex_bubble(idex_bubble0),
        .fetch_en(fetch_en0), .halted(halted0), .stall_count(stall_count0)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] rd;
        logic       wr;
        logic       halt;
        logic       br;
        logic       e_hold;
        logic       e_flush;
        logic       e_bubble;
        logic       e_fetch;
        int         e_cnt;
        logic       e_halted;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(logic v, int rs, int rt, logic urs, logic urt, int rd,
                                logic wr, logic hl, logic br, logic eh, logic ef,
                                logic eb, logic efe, int ec, logic ehd);
        vec_t t;
        t.valid = v;   t.rs = 5'(rs);   t.rt = 5'(rt);
        t.use_rs = urs; t.use_rt = urt; t.rd = 5'(rd);
        t.wr = wr;     t.halt = hl;     t.br = br;
        t.e_hold = eh; t.e_flush = ef;  t.e_bubble = eb;
        t.e_fetch = efe; t.e_cnt = ec;  t.e_halted = ehd;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input int rd, input logic wr, input logic hl,
                         input logic br);
        id_valid = v;  id_rs = 5'(rs);  id_rt = 5'(rt);
        id_use_rs = urs; id_use_rt = urt; id_rd = 5'(rd);
        id_wr_en = wr; id_is_halt = hl; ex_branch_taken = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        #2;
        chk("rst_halted", halted, 0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_pc_hold", pc_hold, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_bubble", idex_bubble, 1);
        chk("rst_fetch_en", fetch_en, 0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        //             v  rs rt urs urt rd wr hl br | hold fl bub fe cnt hlt
        tbl[0]  = mk(1,  0, 0, 1, 0,  1, 1, 0, 0,   0, 0, 0, 1, 0, 0); // ADDI R1,R0,10
        tbl[1]  = mk(1,  2, 1, 1, 1,  4, 1, 0, 0,   1, 0, 1, 1, 0, 0); // ADD R4,R2,R1
        tbl[2]  = mk(1,  2, 1, 1, 1,  4, 1, 0, 0,   1, 0, 1, 1, 1, 0);
        tbl[3]  = mk(1,  2, 1, 1, 1,  4, 1, 0, 0,   0, 0, 0, 1, 2, 0);
        tbl[4]  = mk(1,  0, 0, 1, 0,  0, 1, 0, 0,   0, 0, 0, 1, 2, 0); // ADDI R0,R0,5
        tbl[5]  = mk(1,  0, 0, 1, 1,  4, 1, 0, 0,   0, 0, 0, 1, 2, 0); // ADD R4,R0,R0
        tbl[6]  = mk(1, 10, 0, 1, 0, 10, 1, 0, 0,   0, 0, 0, 1, 2, 0); // SUBI R10,R10,1
        tbl[7]  = mk(1,  0,10, 0, 1,  0, 0, 0, 1,   0, 1, 1, 1, 2, 0); // BNEQZ R10 + flush
        tbl[8]  = mk(1,  0,10, 0, 1,  0, 0, 0, 0,   1, 0, 1, 1, 2, 0);
        tbl[9]  = mk(1,  0,10, 0, 1,  0, 0, 0, 0,   0, 0, 0, 1, 3, 0);
        tbl[10] = mk(1,  0, 0, 0, 0,  0, 0, 1, 1,   0, 1, 1, 1, 3, 0); // HLT wrong path
        tbl[11] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 3, 0);
        tbl[12] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 3, 0);
        tbl[13] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 3, 0);
        tbl[14] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 3, 0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].valid, tbl[i].rs, tbl[i].rt, tbl[i].use_rs, tbl[i].use_rt,
                  tbl[i].rd, tbl[i].wr, tbl[i].halt, tbl[i].br);
            #2;
            chk($sformatf("v%0d_pc_hold", i), pc_hold, tbl[i].e_hold);
            chk($sformatf("v%0d_ifid_flush", i), ifid_flush, tbl[i].e_flush);
            chk($sformatf("v%0d_idex_bubble", i), idex_bubble, tbl[i].e_bubble);
            chk($sformatf("v%0d_fetch_en", i), fetch_en, tbl[i].e_fetch);
            chk($sformatf("v%0d_stall_count", i), stall_count, tbl[i].e_cnt);
            chk($sformatf("v%0d_halted", i), halted, tbl[i].e_halted);
            step();
        end

        // Back-to-back RAW on both bypass settings: 2 stalls vs 3 stalls.
        do_reset();
        begin
            logic [4:0] exp1;
            logic [4:0] exp0;
            exp1 = 5'b00110;
            exp0 = 5'b01110;
            for (int c = 0; c < 5; c++) begin
                if (c == 0) drive(1, 0, 0, 1, 0, 1, 1, 0, 0);
                else        drive(1, 2, 1, 1, 1, 4, 1, 0, 0);
                #2;
                chk($sformatf("raw_byp1_c%0d_pc_hold", c), pc_hold, exp1[c]);
                chk($sformatf("raw_byp0_c%0d_pc_hold", c), pc_hold0, exp0[c]);
                step();
            end
            idle();
            #2;
            chk("raw_byp1_stall_count", stall_count, 2);
            chk("raw_byp0_stall_count", stall_count0, 3);
            step();
        end

        // HLT issue at t: fetch stops at t+1, halted appears at t+4 and sticks.
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        chk("hlt_t_fetch_en", fetch_en, 1);
        chk("hlt_t_idex_bubble", idex_bubble, 0);
        step();
        drive(1, 2, 1, 1, 1, 4, 1, 0, 0);
        for (int c = 1; c <= 24; c++) begin
            #2;
            chk($sformatf("hlt_t%0d_fetch_en", c), fetch_en, 0);
            chk($sformatf("hlt_t%0d_idex_bubble", c), idex_bubble, 1);
            chk($sformatf("hlt_t%0d_halted", c), halted, (c >= 4) ? 1 : 0);
            if (c == 1) chk("hlt_t1_pc_hold", pc_hold, 0);
            step();
        end

        // Reset during the second stall cycle discards the stall and scoreboard.
        do_reset();
        drive(1, 0, 0, 1, 0, 1, 1, 0, 0);
        step();
        drive(1, 2, 1, 1, 1, 4, 1, 0, 0);
        #2;
        chk("rms_stall1_pc_hold", pc_hold, 1);
        step();
        #2;
        chk("rms_stall2_pc_hold", pc_hold, 1);
        chk("rms_stall2_count", stall_count, 1);
        rst = 1'b1;
        #1;
        chk("rms_rst_pc_hold", pc_hold, 0);
        chk("rms_rst_ifid_flush", ifid_flush, 1);
        chk("rms_rst_idex_bubble", idex_bubble, 1);
        chk("rms_rst_fetch_en", fetch_en, 0);
        step();
        rst = 1'b0;
        #2;
        chk("rms_after_pc_hold", pc_hold, 0);
        chk("rms_after_idex_bubble", idex_bubble, 0);
        chk("rms_after_count", stall_count, 0);
        step();
        idle();
        #2;
        chk("rms_next_count", stall_count, 0);
        chk("rms_next_pc_hold", pc_hold, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
